instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front end of the MIPS datapath, directly upstream of `instruction_memory`. It owns the program counter and drives `pc_address` into the combinational instruction memory. It captures the returned `ir` into the IF/ID pipeline register. It selects the next PC among sequential, branch and jump targets, and handles stall, flush and halt requests from the hazard and control logic.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `stall`  in  1  hold PC and IF/ID (load-use hazard).
- `flush`  in  1  squash IF/ID contents.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination byte address.
- `jump`  in  1  redirect to `jump_target`; has priority over `branch_taken`.
- `jump_target`  in  32  jump destination byte address.
- `halt_req`  in  1  stop fetching permanently until reset.
- `imem_ir`  in  32  instruction returned combinationally by instruction memory for `pc_address`.
- `pc_address`  out  32  current PC, registered, byte address.
- `ifid_ir`  out  32  latched instruction; 0 (NOP) when invalid.
- `ifid_pc_plus4`  out  32  latched PC+4 of `ifid_ir`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  FSM is in HALT.
- `fetch_count`  out  32  number of instructions loaded into IF/ID; saturating.
- `misalign_err`  out  1  sticky misaligned-target flag; present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- FSM has three states: BOOT, RUN and HALT. Reset enters BOOT.
- **BOOT** lasts exactly one cycle.
  - PC stays at `RESET_PC`.
  - `ifid_valid` stays 0.
  - Next state is RUN. If `halt_req`=1, next state is HALT instead.
- **RUN**: per rising edge, the first matching rule applies.
  1. `halt_req`: go to HALT. PC holds. IF/ID is squashed: `ifid_valid`=0, `ifid_ir`=0, `ifid_pc_plus4`=0.
  2. `jump`: PC <= `{jump_target[31:2],2'b00}`. IF/ID is squashed.
  3. `branch_taken`: PC <= `{branch_target[31:2],2'b00}`. IF/ID is squashed.
  4. `stall`: PC and IF/ID hold. `flush` is ignored.
  5. `flush`: IF/ID is squashed. PC <= PC+4.
  6. Otherwise: PC <= PC+4, `ifid_ir` <= `imem_ir`, `ifid_pc_plus4` <= PC+4, `ifid_valid` <= 1, and `fetch_count` increments.
- Redirects override `stall` and `flush`.
- **HALT**: PC, IF/ID and `fetch_count` are frozen. `ifid_valid`=0 and `halted`=1. All inputs except `rst_n` are ignored.
- Arithmetic:
  - PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - The PC is not range-checked against memory size.
  - `fetch_count` saturates at 32'hFFFF_FFFF.

## Timing
- Reset values, applied on the first rising edge with `rst_n`=0:
  - `pc_address`=`RESET_PC`.
  - `ifid_ir`=0, `ifid_pc_plus4`=0, `ifid_valid`=0.
  - `halted`=0, `fetch_count`=0, `misalign_err`=0.
  - FSM state is BOOT.
- Reset mid-operation (in any state, including HALT) takes effect at that edge and overrides every other input.
- `pc_address` changes only on clock edges. `imem_ir` must settle within the same cycle, because instruction memory is combinational.
- Fetch latency: the instruction at PC N appears on `ifid_ir` one edge after `pc_address`=N.
- Redirect latency:
  - A redirect asserted in cycle T sets `pc_address` to the target after edge T.
  - The target instruction is valid in IF/ID after edge T+1.
  - The edge-T IF/ID slot is a bubble.
- The first valid instruction after reset release is `RESET_PC`, visible 2 edges after the last reset edge (one BOOT cycle, then one fetch).
- `halted` rises at the edge that enters HALT.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A taken redirect whose selected target has bits [1:0] not equal to 00 sets `misalign_err`=1. The flag is sticky until reset.
  - The FSM enters HALT instead of redirecting. PC holds and IF/ID is squashed.
- Undefined:
  - Target bits [1:0] are silently forced to 00.
  - No `misalign_err` port exists.

## Test plan
- Reset with `RESET_PC`=0, memory words 0..3 = A,B,C,D, no control inputs -> `pc_address` 0,0,4,8,12 on successive edges after release. IF/ID receives A at edge 2 and B at edge 3. `fetch_count` = 2 after edge 3.
- `stall` held 2 cycles while `pc_address`=8 -> `pc_address` and `ifid_ir` unchanged for 2 edges. Sequential fetch then resumes at 12. `fetch_count` does not increment during the stall.
- `branch_taken`=1, `branch_target`=32'h40 together with `jump`=1, `jump_target`=32'h80, plus `stall`=1 -> next `pc_address`=32'h80. IF/ID becomes ir=0, valid=0 for one edge, then holds the word at 0x80.
- PC at 32'hFFFF_FFFC, no control -> next `pc_address`=0 and `ifid_pc_plus4`=0.
- `halt_req` pulse, then `jump`, `flush` and `stall` toggled randomly for 10 cycles -> `halted`=1, PC frozen and `ifid_valid`=0 throughout. `rst_n`=0 for one edge returns PC to `RESET_PC` with `halted`=0.
- With `FETCH_ALIGN_CHECK_EN`: `jump_target`=32'h42 -> `misalign_err`=1 and `halted`=1, and PC holds its old value. Without the macro: the same stimulus gives `pc_address`=32'h40.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID register for the MIPS front end.
//   Parameter RESET_PC    : word-aligned PC value loaded on reset.
//   clk, rst_n            : clock, synchronous active-low reset.
//   stall, flush          : hold PC and IF/ID, or squash IF/ID.
//   branch_taken/_target  : redirect to branch target.
//   jump/jump_target      : redirect to jump target (beats branch).
//   halt_req              : stop fetching until reset.
//   imem_ir               : combinational instruction memory data for pc_address.
//   pc_address            : registered PC driving instruction memory.
//   ifid_ir/_pc_plus4/_valid : IF/ID pipeline register.
//   halted, fetch_count   : HALT state flag, saturating count of loaded instructions.
//   misalign_err          : sticky misaligned-redirect flag, only with FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic [31:0] imem_ir,
    output logic [31:0] pc_address,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t state, state_nx;
    logic [31:0] pc_nx, ir_nx, pc4_nx, count_nx;
    logic        valid_nx, squash;
    logic [31:0] pc_plus4, target;
    logic        redirect;
    assign pc_plus4 = pc_address + 32'd4;
    assign redirect = jump | branch_taken;
    assign target   = jump ? jump_target : branch_target;
    assign halted   = (state == HALT);
`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_nx;
`endif
    always_comb begin
        state_nx = state;
        pc_nx    = pc_address;
        count_nx = fetch_count;
        squash   = 1'b0;
        ir_nx    = ifid_ir;
        pc4_nx   = ifid_pc_plus4;
        valid_nx = ifid_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_nx = misalign_err;
`endif
        case (state)
            BOOT: state_nx = halt_req ? HALT : RUN;
            RUN: begin
                if (halt_req) begin
                    state_nx = HALT;
                    squash   = 1'b1;
                end else if (redirect) begin
                    squash = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (|target[1:0]) begin
                        state_nx    = HALT;
                        misalign_nx = 1'b1;
                    end else begin
                        pc_nx = {target[31:2], 2'b00};
                    end
`else
                    pc_nx = {target[31:2], 2'b00};
`endif
                end else if (stall) begin
                    pc_nx = pc_address;
                end else if (flush) begin
                    squash = 1'b1;
                    pc_nx  = pc_plus4;
                end else begin
                    pc_nx    = pc_plus4;
                    ir_nx    = imem_ir;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                    count_nx = &fetch_count ? fetch_count : fetch_count + 32'd1;
                end
            end
            default: state_nx = HALT;
        endcase
        if (squash) begin
            ir_nx    = 32'd0;
            pc4_nx   = 32'd0;
            valid_nx = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_address    <= RESET_PC;
            ifid_ir       <= 32'd0;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
            fetch_count   <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err  <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            pc_address    <= pc_nx;
            ifid_ir       <= ir_nx;
            ifid_pc_plus4 <= pc4_nx;
            ifid_valid    <= valid_nx;
            fetch_count   <= count_nx;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err  <= misalign_nx;
`endif
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, branch_taken, jump, halt_req;
    logic [31:0] branch_target, jump_target, imem_ir;
    logic [31:0] pc_address, ifid_ir, ifid_pc_plus4, fetch_count;
    logic        ifid_valid, halted;
    int          total = 0;
    int          bad = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt_req(halt_req),
        .imem_ir(imem_ir), .pc_address(pc_address), .ifid_ir(ifid_ir),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: word at address a is 0x1000_0000 + a.
    assign imem_ir = 32'h1000_0000 + pc_address;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; halt_req = 0;
        branch_target = 0; jump_target = 0;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                          input logic [31:0] p4, input logic v, input logic [31:0] cnt);
        chk({tag, "_pc"}, pc_address, pc);
        chk({tag, "_ir"}, ifid_ir, ir);
        chk({tag, "_pc4"}, ifid_pc_plus4, p4);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, "_cnt"}, fetch_count, cnt);
    endtask

    initial begin
        clear();
        rst_n = 0;
        step();
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        rst_n = 1;
        step();
        chk_if("boot", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        chk_if("fetch_a", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        step();
        chk_if("fetch_b", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2);
        stall = 1;
        step();
        chk_if("stall1", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2);
        step();
        chk_if("stall2", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2);
        stall = 0;
        step();
        chk_if("resume", 32'hC, 32'h1000_0008, 32'hC, 1'b1, 32'd3);
        branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80; stall = 1;
        step();
        chk_if("jump_prio", 32'h80, 32'h0, 32'h0, 1'b0, 32'd3);
        clear();
        step();
        chk_if("jump_tgt", 32'h84, 32'h1000_0080, 32'h84, 1'b1, 32'd4);
        flush = 1;
        step();
        chk_if("flush", 32'h88, 32'h0, 32'h0, 1'b0, 32'd4);
        clear();
        branch_taken = 1; branch_target = 32'h200; flush = 1;
        step();
        chk_if("branch", 32'h200, 32'h0, 32'h0, 1'b0, 32'd4);
        clear();
        step();
        chk_if("branch_tgt", 32'h204, 32'h1000_0200, 32'h204, 1'b1, 32'd5);
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step();
        chk_if("jump_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd5);
        clear();
        step();
        chk_if("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1, 32'd6);
        step();
        chk_if("after_wrap", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd7);
        halt_req = 1;
        step();
        chk_if("halt", 32'h4, 32'h0, 32'h0, 1'b0, 32'd7);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            jump = 1'($urandom_range(0, 1));
            jump_target = 32'h80;
            branch_taken = 1'($urandom_range(0, 1));
            branch_target = 32'h40;
            flush = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
            step();
            chk_if("halt_hold", 32'h4, 32'h0, 32'h0, 1'b0, 32'd7);
            chk("halt_hold_flag", {31'd0, halted}, 32'd1);
        end
        clear();
        rst_n = 0;
        step();
        chk_if("rst_from_halt", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst_from_halt_flag", {31'd0, halted}, 32'd0);
        rst_n = 1; halt_req = 1;
        step();
        chk("boot_halt_flag", {31'd0, halted}, 32'd1);
        chk("boot_halt_pc", pc_address, 32'h0);
        clear();
        step();
        chk_if("boot_halt_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        step();
        chk_if("refetch", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        jump = 1; jump_target = 32'h42;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_err", {31'd0, misalign_err}, 32'd1);
        chk("misalign_halted", {31'd0, halted}, 32'd1);
        chk_if("misalign", 32'h4, 32'h0, 32'h0, 1'b0, 32'd1);
        clear();
        step();
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        rst_n = 0;
        step();
        chk("misalign_rst", {31'd0, misalign_err}, 32'd0);
        rst_n = 1;
`else
        chk("misalign_halted", {31'd0, halted}, 32'd0);
        chk_if("misalign", 32'h40, 32'h0, 32'h0, 1'b0, 32'd1);
        clear();
        step();
        chk_if("misalign_next", 32'h44, 32'h1000_0040, 32'h44, 1'b1, 32'd2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
